// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: bundles both requester ports, the data-memory side and the
// statistics outputs of the dm arbiter.
//   slave  : the arbiter's view (takes requests, drives grants and dm_*).
//   master : the environment's view (requesters and the dm itself).
interface dm_arbiter_if #(
   parameter int AW = 9,
   parameter int DW = 32
);
   // port 0: CPU load/store path
   logic          req0;
   logic          we0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] wdata0;
   logic [1:0]    memop0;
   logic          gnt0;
   logic          rvalid0;
   logic [DW-1:0] rdata0;

   // port 1: debug / loader master
   logic          req1;
   logic          we1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata1;
   logic [1:0]    memop1;
   logic          gnt1;
   logic          rvalid1;
   logic [DW-1:0] rdata1;

   // data-memory port
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_din;
   logic [1:0]    dm_memop;
   logic [DW-1:0] dm_dout;

   // statistics (zero unless the counters are built in)
   logic [31:0]   stat_gnt0;
   logic [31:0]   stat_gnt1;
   logic [31:0]   stat_conf;

   modport slave (
      input  req0, we0, addr0, wdata0, memop0,
      input  req1, we1, addr1, wdata1, memop1,
      input  dm_dout,
      output gnt0, rvalid0, rdata0,
      output gnt1, rvalid1, rdata1,
      output dm_we, dm_addr, dm_din, dm_memop,
      output stat_gnt0, stat_gnt1, stat_conf
   );

   modport master (
      output req0, we0, addr0, wdata0, memop0,
      output req1, we1, addr1, wdata1, memop1,
      output dm_dout,
      input  gnt0, rvalid0, rdata0,
      input  gnt1, rvalid1, rdata1,
      input  dm_we, dm_addr, dm_din, dm_memop,
      input  stat_gnt0, stat_gnt1, stat_conf
   );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single data-memory port between the CPU (port 0)
// and the debug/loader master (port 1). Round-robin ownership with a bounded
// hold of MAX_HOLD consecutive owned cycles while the other port waits.
// Grant latency from IDLE is one cycle; read data returns registered one
// cycle after the access.
// Optional macro ARB_STATS_EN builds the grant/contention counters; without
// it the stat_* outputs are tied to zero.
module dm_arbiter #(
   parameter int AW       = 9,
   parameter int DW       = 32,
   parameter int MAX_HOLD = 8
) (
   input logic         clk,
   input logic         rst,
   dm_arbiter_if.slave bus
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_ONE = HW'(1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OWN0 = 2'd1;
   localparam logic [1:0] OWN1 = 2'd2;

   logic [1:0]    state, state_nxt;
   logic          last_winner, last_nxt;
   logic [HW-1:0] hold_cnt, hold_nxt;

   logic          gnt0, gnt1;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_din;
   logic [1:0]    dm_memop;
   logic          rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;

   // The owner is granted in any cycle it still requests.
   assign gnt0 = (state == OWN0) & bus.req0;
   assign gnt1 = (state == OWN1) & bus.req1;

   // Route the granted port onto dm; drive all zeros when nobody is granted.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      dm_we    = 1'b0;
      dm_addr  = '0;
      dm_din   = '0;
      dm_memop = 2'b00;
      if (gnt0) begin
         dm_we    = bus.we0;
         dm_addr  = bus.addr0;
         dm_din   = bus.wdata0;
         dm_memop = bus.memop0;
      end else if (gnt1) begin
         dm_we    = bus.we1;
         dm_addr  = bus.addr1;
         dm_din   = bus.wdata1;
         dm_memop = bus.memop1;
      end
   end

   // Ownership decisions: tie-break on last_winner, forced hand-off at MAX_HOLD.
   always_comb begin
      state_nxt = state;
      last_nxt  = last_winner;
      hold_nxt  = hold_cnt;
      unique case (state)
         IDLE: begin
            if (bus.req0 & (~bus.req1 | last_winner)) begin
               state_nxt = OWN0;
               last_nxt  = 1'b0;
               hold_nxt  = HOLD_ONE;
            end else if (bus.req1) begin
               state_nxt = OWN1;
               last_nxt  = 1'b1;
               hold_nxt  = HOLD_ONE;
            end
         end
         OWN0: begin
            if (bus.req1 & (~bus.req0 | (hold_cnt == HOLD_MAX))) begin
               state_nxt = OWN1;
               last_nxt  = 1'b1;
               hold_nxt  = HOLD_ONE;
            end else if (~bus.req0) begin
               state_nxt = IDLE;
               hold_nxt  = '0;
            end else if (hold_cnt != HOLD_MAX) begin
               hold_nxt = hold_cnt + HOLD_ONE;
            end
         end
         OWN1: begin
            if (bus.req0 & (~bus.req1 | (hold_cnt == HOLD_MAX))) begin
               state_nxt = OWN0;
               last_nxt  = 1'b0;
               hold_nxt  = HOLD_ONE;
            end else if (~bus.req1) begin
               state_nxt = IDLE;
               hold_nxt  = '0;
            end else if (hold_cnt != HOLD_MAX) begin
               hold_nxt = hold_cnt + HOLD_ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
            hold_nxt  = '0;
         end
      endcase
   end

   // Arbiter state register; port 0 wins the first tie after reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state       <= IDLE;
         last_winner <= 1'b1;
         hold_cnt    <= '0;
      end else begin
         state       <= state_nxt;
         last_winner <= last_nxt;
         hold_cnt    <= hold_nxt;
      end
   end

   // Registered read return: capture dm_dout on a granted read, flag it one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         rvalid0 <= gnt0 & ~bus.we0;
         rvalid1 <= gnt1 & ~bus.we1;
         if (gnt0 & ~bus.we0) rdata0 <= bus.dm_dout;
         if (gnt1 & ~bus.we1) rdata1 <= bus.dm_dout;
      end
   end

   assign bus.gnt0     = gnt0;
   assign bus.gnt1     = gnt1;
   assign bus.rvalid0  = rvalid0;
   assign bus.rvalid1  = rvalid1;
   assign bus.rdata0   = rdata0;
   assign bus.rdata1   = rdata1;
   assign bus.dm_we    = dm_we;
   assign bus.dm_addr  = dm_addr;
   assign bus.dm_din   = dm_din;
   assign bus.dm_memop = dm_memop;

`ifdef ARB_STATS_EN
   logic [31:0] cnt_gnt0, cnt_gnt1, cnt_conf;

   // Granted cycles per port and contended cycles; counters wrap at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_gnt0 <= '0;
         cnt_gnt1 <= '0;
         cnt_conf <= '0;
      end else begin
         cnt_gnt0 <= cnt_gnt0 + {31'b0, gnt0};
         cnt_gnt1 <= cnt_gnt1 + {31'b0, gnt1};
         cnt_conf <= cnt_conf + {31'b0, bus.req0 & bus.req1};
      end
   end

   assign bus.stat_gnt0 = cnt_gnt0;
   assign bus.stat_gnt1 = cnt_gnt1;
   assign bus.stat_conf = cnt_conf;
`else
   assign bus.stat_gnt0 = '0;
   assign bus.stat_gnt1 = '0;
   assign bus.stat_conf = '0;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: vector table, hand-written corner sequences and a random
// run against a cycle-level reference model of the dm arbiter.
// Build with +define+ARB_STATS_EN to also check the statistics counters.
module tb_dm_arbiter;

   localparam int AW       = 9;
   localparam int DW       = 32;
   localparam int MAX_HOLD = 8;

   logic clk;
   logic rst;

   dm_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   dm_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- data memory model (the dm behind the arbiter) --------
   logic [DW-1:0] dm_mem [0:511];
   logic          pre_we;
   logic [AW-1:0] pre_addr;
   logic [DW-1:0] pre_data;

   assign bus.dm_dout = dm_mem[bus.dm_addr];

   always @(posedge clk) begin
      if (pre_we)          dm_mem[pre_addr]    <= pre_data;
      else if (bus.dm_we)  dm_mem[bus.dm_addr] <= bus.dm_din;
   end

   // ---------------- bookkeeping -----------------------------------------
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- requester stimulus state ----------------------------
   logic          rq [2];
   logic          wq [2];
   logic [AW-1:0] aq [2];
   logic [DW-1:0] dq [2];
   logic [1:0]    mq [2];

   task automatic drive();
      bus.req0 = rq[0]; bus.we0 = wq[0]; bus.addr0 = aq[0]; bus.wdata0 = dq[0]; bus.memop0 = mq[0];
      bus.req1 = rq[1]; bus.we1 = wq[1]; bus.addr1 = aq[1]; bus.wdata1 = dq[1]; bus.memop1 = mq[1];
   endtask

   task automatic set_port(input int p, input logic r, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [1:0] m);
      rq[p] = r; wq[p] = w; aq[p] = a; dq[p] = d; mq[p] = m;
   endtask

   // ---------------- reference model --------------------------------------
   // owner: -1 none, else port number; run: consecutive owned cycles so far.
   logic [DW-1:0] ref_mem [0:511];
   int            own, run, last;
   logic          exp_rv [2];
   logic [DW-1:0] exp_rd [2];
   logic          eg [2];
   int            sg0, sg1, sc;

   task automatic model_reset();
      own = -1; run = 0; last = 1;
      for (int p = 0; p < 2; p++) begin exp_rv[p] = 1'b0; exp_rd[p] = '0; end
      sg0 = 0; sg1 = 0; sc = 0;
   endtask

   task automatic take(input int p);
      own = p; last = p; run = 1;
   endtask

   // Advance the model by one clock edge using this cycle's requests.
   task automatic model_clock();
      for (int p = 0; p < 2; p++) begin
         exp_rv[p] = eg[p] && !wq[p];
         if (exp_rv[p]) exp_rd[p] = ref_mem[aq[p]];
      end
      for (int p = 0; p < 2; p++) if (eg[p] && wq[p]) ref_mem[aq[p]] = dq[p];
      sg0 += int'(eg[0]); sg1 += int'(eg[1]); sc += int'(rq[0] && rq[1]);
      if (own < 0) begin
         if (rq[0] && rq[1]) take(1 - last);
         else if (rq[0])     take(0);
         else if (rq[1])     take(1);
      end else begin
         automatic int other = 1 - own;
         if (!rq[own]) begin
            if (rq[other]) take(other); else own = -1;
         end else if (rq[other] && run >= MAX_HOLD) begin
            take(other);
         end else if (run < MAX_HOLD) begin
            run++;
         end
      end
   endtask

   task automatic new_txn(input int p);
      wq[p] = 1'($urandom_range(0, 1));
      aq[p] = AW'($urandom_range(0, 15) * 4);
      dq[p] = $urandom;
      mq[p] = 2'($urandom_range(0, 3));
   endtask

   // Reset for two-plus cycles, preloading 16 words of dm while held.
   task automatic do_reset();
      rst = 1'b1;
      for (int p = 0; p < 2; p++) set_port(p, 1'b0, 1'b0, '0, '0, 2'b00);
      drive();
      for (int i = 0; i < 16; i++) begin
         pre_we   = 1'b1;
         pre_addr = AW'(i * 4);
         pre_data = 32'hC0DE_0000 + 32'(i * 32'h111);
         ref_mem[pre_addr] = pre_data;
         tick();
      end
      pre_we = 1'b0;
      rst    = 1'b0;
      model_reset();
   endtask

   task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d; ref_mem[a] = d;
      tick();
      pre_we = 1'b0;
   endtask

   // ---------------- vector table -----------------------------------------
   typedef struct packed {
      logic r0, w0, r1, w1;
      logic g0, g1, rv0, rv1, dwe;
   } vec_t;

   vec_t vecs [14];

   initial begin
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      rst = 1'b1;

      //            r0 w0 r1 w1   g0 g1 rv0 rv1 dwe
      vecs[0]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[1]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[2]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0};
      vecs[3]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0};
      vecs[4]  = '{1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[5]  = '{1'b1,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0};
      vecs[6]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0};
      vecs[7]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0};
      vecs[8]  = '{1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b0};
      vecs[9]  = '{1'b0,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b1};
      vecs[10] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[11] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};
      vecs[12] = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1};
      vecs[13] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0};

      // ---- reset state and table ----
      do_reset();
      @(negedge clk);
      check("reset gnt0", bus.gnt0, 0);
      check("reset gnt1", bus.gnt1, 0);
      check("reset rvalid0", bus.rvalid0, 0);
      check("reset rvalid1", bus.rvalid1, 0);
      check("reset rdata0", bus.rdata0, 0);
      check("reset rdata1", bus.rdata1, 0);
      check("reset dm_addr", bus.dm_addr, 0);
      check("reset stat_gnt0", bus.stat_gnt0, 0);
      check("reset stat_conf", bus.stat_conf, 0);
      tick();
      for (int i = 0; i < 14; i++) begin
         set_port(0, vecs[i].r0, vecs[i].w0, 9'h004, 32'hA0A0_0000 + 32'(i), 2'b10);
         set_port(1, vecs[i].r1, vecs[i].w1, 9'h008, 32'hB0B0_0000 + 32'(i), 2'b10);
         drive();
         @(negedge clk);
         check($sformatf("vec%0d gnt0", i), bus.gnt0, vecs[i].g0);
         check($sformatf("vec%0d gnt1", i), bus.gnt1, vecs[i].g1);
         check($sformatf("vec%0d rvalid0", i), bus.rvalid0, vecs[i].rv0);
         check($sformatf("vec%0d rvalid1", i), bus.rvalid1, vecs[i].rv1);
         check($sformatf("vec%0d dm_we", i), bus.dm_we, vecs[i].dwe);
         tick();
      end

      // ---- port 0 read after reset: grant on cycle 2, data on cycle 3 ----
      do_reset();
      poke(9'h010, 32'hDEAD_BEEF);
      set_port(0, 1'b1, 1'b0, 9'h010, '0, 2'b10); drive();
      @(negedge clk); check("rd0 c1 gnt0", bus.gnt0, 0); tick();
      @(negedge clk); check("rd0 c2 gnt0", bus.gnt0, 1); check("rd0 c2 dm_addr", bus.dm_addr, 32'h010);
      tick(); rq[0] = 1'b0; drive();
      @(negedge clk);
      check("rd0 c3 rvalid0", bus.rvalid0, 1);
      check("rd0 c3 rdata0", bus.rdata0, 32'hDEAD_BEEF);
      check("rd0 c3 gnt1", bus.gnt1, 0);
      tick();
      @(negedge clk); check("rd0 c4 rvalid0", bus.rvalid0, 0); check("rd0 c4 rdata0 hold", bus.rdata0, 32'hDEAD_BEEF);
      tick();

      // ---- port 1 write then read of the same address ----
      do_reset();
      set_port(1, 1'b1, 1'b1, 9'h020, 32'h1234_5678, 2'b10); drive();
      @(negedge clk); check("wr1 c1 gnt1", bus.gnt1, 0); tick();
      @(negedge clk);
      check("wr1 c2 gnt1", bus.gnt1, 1);
      check("wr1 c2 dm_we", bus.dm_we, 1);
      check("wr1 c2 dm_din", bus.dm_din, 32'h1234_5678);
      check("wr1 c2 dm_memop", bus.dm_memop, 2'b10);
      tick(); wq[1] = 1'b0; dq[1] = '0; drive();
      @(negedge clk);
      check("wr1 c3 gnt1", bus.gnt1, 1);
      check("wr1 c3 dm_we", bus.dm_we, 0);
      check("wr1 c3 rvalid1", bus.rvalid1, 0);
      tick(); rq[1] = 1'b0; drive();
      @(negedge clk);
      check("wr1 c4 rvalid1", bus.rvalid1, 1);
      check("wr1 c4 rdata1", bus.rdata1, 32'h1234_5678);
      tick();

      // ---- continuous contention: runs of MAX_HOLD grants alternate ----
      do_reset();
      set_port(0, 1'b1, 1'b0, 9'h000, '0, 2'b10);
      set_port(1, 1'b1, 1'b0, 9'h004, '0, 2'b10);
      drive();
      for (int k = 0; k < 3 * MAX_HOLD + 1; k++) begin
         automatic int who = (k == 0) ? -1 : (((k - 1) / MAX_HOLD) % 2);
         @(negedge clk);
         check($sformatf("hold k%0d gnt0", k), bus.gnt0, 32'(who == 0));
         check($sformatf("hold k%0d gnt1", k), bus.gnt1, 32'(who == 1));
         tick();
      end

      // ---- synchronous reset during OWN1 ----
      do_reset();
      set_port(1, 1'b1, 1'b0, 9'h00C, '0, 2'b10); drive();
      @(negedge clk); check("rst1 c1 gnt1", bus.gnt1, 0); tick();
      @(negedge clk); check("rst1 c2 gnt1", bus.gnt1, 1); tick();
      rst = 1'b1;
      @(negedge clk);
      check("rst1 c3 gnt1", bus.gnt1, 1);
      check("rst1 c3 dm_addr", bus.dm_addr, 32'h00C);
      check("rst1 c3 rvalid1", bus.rvalid1, 1);
      tick(); rst = 1'b0;
      @(negedge clk); check("rst1 c4 gnt1", bus.gnt1, 0); check("rst1 c4 rvalid1", bus.rvalid1, 0); tick();
      @(negedge clk); check("rst1 c5 gnt1", bus.gnt1, 1); tick();
      rq[1] = 1'b0; drive(); tick();

      // ---- statistics: 10 contended cycles then 3 port-0-only cycles ----
      do_reset();
      set_port(0, 1'b1, 1'b0, 9'h000, '0, 2'b10);
      set_port(1, 1'b1, 1'b0, 9'h004, '0, 2'b10);
      drive();
      for (int k = 0; k < 10; k++) tick();
      rq[1] = 1'b0; drive();
      for (int k = 0; k < 3; k++) tick();
      rq[0] = 1'b0; drive();
      @(negedge clk);
`ifdef ARB_STATS_EN
      check("stats conf", bus.stat_conf, 10);
      check("stats gnt0", bus.stat_gnt0, 10);
      check("stats gnt1", bus.stat_gnt1, 1);
      check("stats sum", bus.stat_gnt0 + bus.stat_gnt1, 11);
`else
      check("stats conf off", bus.stat_conf, 0);
      check("stats gnt0 off", bus.stat_gnt0, 0);
      check("stats gnt1 off", bus.stat_gnt1, 0);
`endif
      tick();

      // ---- randomized traffic against the reference model ----
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         automatic logic          x_we   = 1'b0;
         automatic logic [AW-1:0] x_addr = '0;
         automatic logic [DW-1:0] x_din  = '0;
         automatic logic [1:0]    x_mop  = 2'b00;
         drive();
         for (int p = 0; p < 2; p++) begin
            eg[p] = (own == p) && rq[p];
            if (eg[p]) begin x_we = wq[p]; x_addr = aq[p]; x_din = dq[p]; x_mop = mq[p]; end
         end
         @(negedge clk);
         check("rnd gnt0", bus.gnt0, eg[0]);
         check("rnd gnt1", bus.gnt1, eg[1]);
         check("rnd dm_we", bus.dm_we, x_we);
         check("rnd dm_addr", bus.dm_addr, x_addr);
         check("rnd dm_din", bus.dm_din, x_din);
         check("rnd dm_memop", bus.dm_memop, x_mop);
         check("rnd rvalid0", bus.rvalid0, exp_rv[0]);
         check("rnd rvalid1", bus.rvalid1, exp_rv[1]);
         check("rnd rdata0", bus.rdata0, exp_rd[0]);
         check("rnd rdata1", bus.rdata1, exp_rd[1]);
         model_clock();
         for (int p = 0; p < 2; p++) begin
            if (eg[p]) begin
               if ($urandom_range(0, 99) < 80) new_txn(p); else rq[p] = 1'b0;
            end else if (!rq[p] && $urandom_range(0, 99) < 50) begin
               rq[p] = 1'b1;
               new_txn(p);
            end
         end
         tick();
      end
      rq[0] = 1'b0; rq[1] = 1'b0; drive();
      @(negedge clk);
`ifdef ARB_STATS_EN
      check("rnd stat_gnt0", bus.stat_gnt0, 32'(sg0));
      check("rnd stat_gnt1", bus.stat_gnt1, 32'(sg1));
      check("rnd stat_conf", bus.stat_conf, 32'(sc));
`else
      check("rnd stat_gnt0 off", bus.stat_gnt0, 0);
      check("rnd stat_conf off", bus.stat_conf, 0);
`endif
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
